// File: rtl/ctrl_ps2_pkg.sv
// Shared definitions for the PS/2 keyboard capture sequencer.
// Holds the FSM state encoding and default configuration values.
package ctrl_ps2_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        WAIT_ENTER = 2'b01,
        WAIT_DATO  = 2'b10,
        CHECK      = 2'b11
    } state_t;

    localparam int DEF_NUM_FIELDS     = 3;
    localparam int DEF_TIMEOUT_CYCLES = 50_000_000;

    // The two states that wait on the operator and may time out.
    function automatic logic is_wait(input state_t s);
        return (s == WAIT_ENTER) || (s == WAIT_DATO);
    endfunction

endpackage

// File: rtl/ctrl_ps2_timer.sv
// Inactivity timer for the capture sequencer.
// Counts cycles while run is high; clr restarts the count from zero.
// expired is high during the cycle in which the count sits at
// TIMEOUT_CYCLES-1, so the owner reacts on the following edge.
module ctrl_ps2_timer
    import ctrl_ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int                CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, then increment saturating at the expiry value.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = run && (count_q == LAST);

endmodule

// File: rtl/control_ps2_multi.sv
// Keyboard capture sequencer: Ctrl starts a sequence of NUM_FIELDS fields,
// each entered as Enter followed by a data key. Emits a save strobe per
// field, a completion pulse after the last one, and an abort pulse on Esc.
// Optional inactivity timeout is compiled in with CTRL_PS2_TIMEOUT_EN.
// All outputs are registered; rst is asynchronous and active-low.
module control_ps2_multi
    import ctrl_ps2_pkg::*;
#(
    parameter int NUM_FIELDS     = DEF_NUM_FIELDS,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl,
    input  logic             enter,
    input  logic             dato,
    input  logic             esc,
    output logic             salvar,
    output logic [IDX_W-1:0] field_idx,
    output logic             datos_listos,
    output logic             aborto,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

    // Reject configurations the index register cannot represent.
    if ((NUM_FIELDS < 1) || (NUM_FIELDS > 16) || ((1 << IDX_W) < NUM_FIELDS) ||
        (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
        $error("control_ps2_multi: illegal NUM_FIELDS/IDX_W/TIMEOUT_CYCLES");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] field_idx_q, field_idx_d;
    logic             salvar_q, salvar_d;
    logic             datos_listos_q, datos_listos_d;
    logic             aborto_q, aborto_d;
    logic             busy_q, busy_d;
    logic             timer_expired;

`ifdef CTRL_PS2_TIMEOUT_EN
    logic timer_run;
    logic timer_clr;

    // Count only while waiting; any state change (accepted strobe, entry,
    // exit) restarts the count.
    assign timer_run = is_wait(state_q);
    assign timer_clr = (state_d != state_q);

    ctrl_ps2_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (timer_run),
        .clr     (timer_clr),
        .expired (timer_expired)
    );
`else
    assign timer_expired = 1'b0;
`endif

    // Next-state and next-output logic; illegal strobes simply fall through.
    always_comb begin
        state_d        = state_q;
        field_idx_d    = field_idx_q;
        salvar_d       = 1'b0;
        datos_listos_d = 1'b0;
        aborto_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl) begin
                    state_d     = WAIT_ENTER;
                    field_idx_d = '0;
                end
            end
            WAIT_ENTER: begin
                if (esc || timer_expired) begin
                    state_d  = IDLE;
                    aborto_d = 1'b1;
                end else if (enter) begin
                    state_d = WAIT_DATO;
                end
            end
            WAIT_DATO: begin
                if (esc || timer_expired) begin
                    state_d  = IDLE;
                    aborto_d = 1'b1;
                end else if (dato) begin
                    state_d  = CHECK;
                    salvar_d = 1'b1;
                end
            end
            CHECK: begin
                if (field_idx_q == LAST_IDX) begin
                    state_d        = IDLE;
                    datos_listos_d = 1'b1;
                end else begin
                    state_d     = WAIT_ENTER;
                    field_idx_d = field_idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            field_idx_q    <= '0;
            salvar_q       <= 1'b0;
            datos_listos_q <= 1'b0;
            aborto_q       <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            field_idx_q    <= field_idx_d;
            salvar_q       <= salvar_d;
            datos_listos_q <= datos_listos_d;
            aborto_q       <= aborto_d;
            busy_q         <= busy_d;
        end
    end

    assign salvar       = salvar_q;
    assign field_idx    = field_idx_q;
    assign datos_listos = datos_listos_q;
    assign aborto       = aborto_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_control_ps2_multi.sv
// Bench for control_ps2_multi: a 3-field instance (A) and a 1-field
// instance (B). Expected pulses are queued as stimulus is applied and
// matched against observed pulses by per-instance monitors.
module tb_control_ps2_multi;

    localparam int K_SAV = 0;
    localparam int K_DL  = 1;
    localparam int K_AB  = 2;

    typedef struct {
        int kind;
        int idx;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_ctrl, a_enter, a_dato, a_esc;
    logic       a_salvar, a_dl, a_ab, a_busy;
    logic [1:0] a_idx;
    logic       b_ctrl, b_enter, b_dato, b_esc;
    logic       b_salvar, b_dl, b_ab, b_busy;
    logic [0:0] b_idx;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    ev_t  qa[$];
    ev_t  qb[$];
    ev_t  ea, eb;
    int   ka, kb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    control_ps2_multi #(.NUM_FIELDS(3), .IDX_W(2), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .rst(rst), .ctrl(a_ctrl), .enter(a_enter), .dato(a_dato),
        .esc(a_esc), .salvar(a_salvar), .field_idx(a_idx),
        .datos_listos(a_dl), .aborto(a_ab), .busy(a_busy)
    );

    control_ps2_multi #(.NUM_FIELDS(1), .IDX_W(1), .TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .rst(rst), .ctrl(b_ctrl), .enter(b_enter), .dato(b_dato),
        .esc(b_esc), .salvar(b_salvar), .field_idx(b_idx),
        .datos_listos(b_dl), .aborto(b_ab), .busy(b_busy)
    );

    // Instance A pulse monitor.
    always @(negedge clk) begin : mon_a
        if (a_salvar || a_dl || a_ab) begin
            checks++;
            ka = a_salvar ? K_SAV : (a_dl ? K_DL : K_AB);
            if ($countones({a_salvar, a_dl, a_ab}) > 1) begin
                errors++;
                $display("FAIL a_exclusive: got salvar=%b dl=%b ab=%b at cyc %0d, want one pulse",
                         a_salvar, a_dl, a_ab, cyc);
            end else if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected: got kind=%0d idx=%0d at cyc %0d, want no pulse",
                         ka, a_idx, cyc);
            end else begin
                ea = qa.pop_front();
                if (ea.kind != ka || ea.cyc != cyc || (ea.idx >= 0 && ea.idx != int'(a_idx))) begin
                    errors++;
                    $display("FAIL a_pulse: got kind=%0d idx=%0d cyc=%0d, want kind=%0d idx=%0d cyc=%0d",
                             ka, a_idx, cyc, ea.kind, ea.idx, ea.cyc);
                end
            end
        end
    end

    // Instance B pulse monitor.
    always @(negedge clk) begin : mon_b
        if (b_salvar || b_dl || b_ab) begin
            checks++;
            kb = b_salvar ? K_SAV : (b_dl ? K_DL : K_AB);
            if ($countones({b_salvar, b_dl, b_ab}) > 1) begin
                errors++;
                $display("FAIL b_exclusive: got salvar=%b dl=%b ab=%b at cyc %0d, want one pulse",
                         b_salvar, b_dl, b_ab, cyc);
            end else if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected: got kind=%0d idx=%0d at cyc %0d, want no pulse",
                         kb, b_idx, cyc);
            end else begin
                eb = qb.pop_front();
                if (eb.kind != kb || eb.cyc != cyc || (eb.idx >= 0 && eb.idx != int'(b_idx))) begin
                    errors++;
                    $display("FAIL b_pulse: got kind=%0d idx=%0d cyc=%0d, want kind=%0d idx=%0d cyc=%0d",
                             kb, b_idx, cyc, eb.kind, eb.idx, eb.cyc);
                end
            end
        end
    end

    task automatic step_a(input logic c, input logic en, input logic d, input logic x);
        a_ctrl = c; a_enter = en; a_dato = d; a_esc = x;
        @(posedge clk); #1;
        a_ctrl = 1'b0; a_enter = 1'b0; a_dato = 1'b0; a_esc = 1'b0;
    endtask

    task automatic step_b(input logic c, input logic en, input logic d, input logic x);
        b_ctrl = c; b_enter = en; b_dato = d; b_esc = x;
        @(posedge clk); #1;
        b_ctrl = 1'b0; b_enter = 1'b0; b_dato = 1'b0; b_esc = 1'b0;
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) step_a(0, 0, 0, 0);
    endtask

    task automatic push_a(input int kind, input int idx, input int c);
        ev_t e;
        e.kind = kind; e.idx = idx; e.cyc = c;
        qa.push_back(e);
    endtask

    task automatic push_b(input int kind, input int idx, input int c);
        ev_t e;
        e.kind = kind; e.idx = idx; e.cyc = c;
        qb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_salvar, a_dl, a_ab, a_busy, a_idx} !== 6'b0) begin
            errors++;
            $display("FAIL reset_a: got %b, want 000000", {a_salvar, a_dl, a_ab, a_busy, a_idx});
        end
        checks++;
        if ({b_salvar, b_dl, b_ab, b_busy, b_idx} !== 5'b0) begin
            errors++;
            $display("FAIL reset_b: got %b, want 00000", {b_salvar, b_dl, b_ab, b_busy, b_idx});
        end
        rst = 1'b1;
        idle_a(1);
        step_a(0, 1, 1, 1);
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores: got busy=%b, want 0", a_busy);
        end
    endtask

    task automatic test_three_fields();
        step_a(1, 0, 0, 0);
        checks++;
        if (a_busy !== 1'b1 || a_idx !== 2'd0) begin
            errors++;
            $display("FAIL start: got busy=%b idx=%0d, want busy=1 idx=0", a_busy, a_idx);
        end
        for (int i = 0; i < 3; i++) begin
            step_a(0, 1, 0, 0);
            step_a(0, 0, 1, 0);
            push_a(K_SAV, i, cyc);
            if (i == 2) push_a(K_DL, 2, cyc + 1);
            step_a(0, 0, 0, 0);
            if (i < 2) begin
                checks++;
                if (a_idx !== 2'(i + 1)) begin
                    errors++;
                    $display("FAIL idx_incr: got %0d, want %0d", a_idx, i + 1);
                end
            end
        end
        checks++;
        if (a_busy !== 1'b0 || a_idx !== 2'd2) begin
            errors++;
            $display("FAIL done: got busy=%b idx=%0d, want busy=0 idx=2", a_busy, a_idx);
        end
        idle_a(2);
    endtask

    task automatic test_reset_mid();
        step_a(1, 0, 0, 0);
        step_a(0, 1, 0, 0);
        step_a(0, 0, 1, 0);
        push_a(K_SAV, 0, cyc);
        step_a(0, 0, 0, 0);
        step_a(0, 1, 0, 0);
        checks++;
        if (a_busy !== 1'b1 || a_idx !== 2'd1) begin
            errors++;
            $display("FAIL mid_state: got busy=%b idx=%0d, want busy=1 idx=1", a_busy, a_idx);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({a_salvar, a_dl, a_ab, a_busy, a_idx} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got %b, want 000000", {a_salvar, a_dl, a_ab, a_busy, a_idx});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        step_a(1, 0, 0, 0);
        step_a(0, 1, 0, 0);
        step_a(0, 0, 1, 0);
        push_a(K_SAV, 0, cyc);
        step_a(0, 0, 0, 0);
        step_a(0, 0, 0, 1);
        push_a(K_AB, -1, cyc);
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %b, want 0", a_busy);
        end
        idle_a(2);
    endtask

    task automatic test_esc_abort();
        step_a(1, 0, 0, 0);
        step_a(0, 1, 0, 0);
        step_a(0, 0, 1, 1);
        push_a(K_AB, -1, cyc);
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL esc_busy: got %b, want 0", a_busy);
        end
        step_a(0, 0, 1, 0);
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL esc_after: got busy=%b, want 0", a_busy);
        end
        idle_a(2);
    endtask

    task automatic test_illegal();
        step_a(1, 0, 0, 0);
        step_a(0, 0, 1, 0);
        step_a(0, 0, 1, 0);
        checks++;
        if (a_busy !== 1'b1 || a_idx !== 2'd0) begin
            errors++;
            $display("FAIL dato_in_wait_enter: got busy=%b idx=%0d, want busy=1 idx=0", a_busy, a_idx);
        end
        step_a(0, 1, 0, 0);
        step_a(0, 1, 0, 0);
        step_a(0, 0, 1, 0);
        push_a(K_SAV, 0, cyc);
        step_a(0, 1, 0, 0);
        step_a(0, 0, 1, 0);
        checks++;
        if (a_busy !== 1'b1 || a_idx !== 2'd1) begin
            errors++;
            $display("FAIL enter_in_check: got busy=%b idx=%0d, want busy=1 idx=1", a_busy, a_idx);
        end
        step_a(1, 0, 0, 0);
        checks++;
        if (a_idx !== 2'd1) begin
            errors++;
            $display("FAIL ctrl_restart: got idx=%0d, want 1", a_idx);
        end
        step_a(0, 1, 0, 0);
        step_a(0, 0, 1, 0);
        push_a(K_SAV, 1, cyc);
        step_a(0, 0, 0, 0);
        step_a(0, 0, 0, 1);
        push_a(K_AB, -1, cyc);
        idle_a(2);
    endtask

    task automatic test_single_field();
        for (int r = 0; r < 2; r++) begin
            step_b(1, 0, 0, 0);
            step_b(0, 1, 0, 0);
            step_b(0, 0, 1, 0);
            push_b(K_SAV, 0, cyc);
            push_b(K_DL, 0, cyc + 1);
            step_b(0, 0, 0, 0);
            checks++;
            if (b_busy !== 1'b0 || b_idx !== 1'b0) begin
                errors++;
                $display("FAIL single_done: got busy=%b idx=%0d, want busy=0 idx=0", b_busy, b_idx);
            end
        end
        step_b(0, 0, 0, 0);
        step_b(0, 0, 0, 0);
    endtask

`ifdef CTRL_PS2_TIMEOUT_EN
    task automatic test_timeout();
        step_a(1, 0, 0, 0);
        push_a(K_AB, -1, cyc + 8);
        idle_a(10);
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_busy: got %b, want 0", a_busy);
        end
        step_a(1, 0, 0, 0);
        idle_a(4);
        step_a(0, 1, 0, 0);
        push_a(K_AB, -1, cyc + 8);
        idle_a(7);
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_restart: got busy=%b, want 1", a_busy);
        end
        idle_a(4);
    endtask
`endif

    initial begin
        a_ctrl = 0; a_enter = 0; a_dato = 0; a_esc = 0;
        b_ctrl = 0; b_enter = 0; b_dato = 0; b_esc = 0;
        rst = 1'b0;
        test_reset();
        test_three_fields();
        test_reset_mid();
        test_esc_abort();
        test_illegal();
        test_single_field();
`ifdef CTRL_PS2_TIMEOUT_EN
        test_timeout();
`endif
        idle_a(2);
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL a_missing: got %0d pulses outstanding, want 0", qa.size());
        end
        checks++;
        if (qb.size() != 0) begin
            errors++;
            $display("FAIL b_missing: got %0d pulses outstanding, want 0", qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
